// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_booth_multiplier
//  Description : Iterative Booth multiplier, radix-2 or radix-4 recoding,
//                signed or unsigned N x N -> 2N product.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_booth_multiplier #(
  parameter int N      = 32,
  parameter bit RADIX4 = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  // Operand width after extension; one extra bit gives unsigned operands a
  // zero sign bit, radix-4 adds one more so the triplet count is whole.
  localparam int W    = RADIX4 ? N + 2 : N + 1;
  localparam int SH   = RADIX4 ? 2 : 1;
  localparam int ITER = RADIX4 ? (N + 2) / 2 : N + 1;
  // Upper accumulator part carries two guard bits so +/-2A cannot overflow.
  localparam int HW   = W + 2;
  // Accumulator layout: {upper[HW-1:0], multiplier field[W-1:0], B[-1]}.
  localparam int L    = HW + W + 1;
  localparam int CW   = $clog2(N + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [L-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  product_q, product_d;

  logic [W-1:0]    a_ext_in;
  logic [W-1:0]    b_ext_in;
  logic [HW-1:0]   a_hw;
  logic [HW-1:0]   addend;
  logic [HW-1:0]   hi_sum;
  logic signed [L-1:0] acc_sum;
  logic signed [L-1:0] acc_shift;

  assign a_ext_in = {{(W-N){is_signed & multiplicand[N-1]}}, multiplicand};
  assign b_ext_in = {{(W-N){is_signed & multiplier[N-1]}}, multiplier};
  assign a_hw     = {{2{a_q[W-1]}}, a_q};

  generate
    if (RADIX4) begin : g_radix4
      // Radix-4 digit select from {B[2i+1], B[2i], B[2i-1]}.
      always_comb begin
        addend = '0;
        case (acc_q[2:0])
          3'b001, 3'b010: addend = a_hw;
          3'b011:         addend = a_hw << 1;
          3'b100:         addend = -(a_hw << 1);
          3'b101, 3'b110: addend = -a_hw;
          default:        addend = '0;
        endcase
      end
    end else begin : g_radix2
      // Radix-2 digit select from {B[i], B[i-1]}.
      always_comb begin
        addend = '0;
        case (acc_q[1:0])
          2'b01:   addend = a_hw;
          2'b10:   addend = -a_hw;
          default: addend = '0;
        endcase
      end
    end
  endgenerate

  // Add the selected digit into the upper part, then shift the whole
  // accumulator arithmetically so the next digit lands in the low bits.
  assign hi_sum    = acc_q[L-1:W+1] + addend;
  assign acc_sum   = {hi_sum, acc_q[W:0]};
  assign acc_shift = acc_sum >>> SH;

  // Next-state, datapath and result capture.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_ext_in;
          acc_d   = {{HW{1'b0}}, b_ext_in, 1'b0};
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          // After W total shifts the full product sits right above B[-1].
          product_d = acc_shift[2*N:1];
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_booth_multiplier
//  Description : Directed bench for seq_booth_multiplier, N=8 and N=32,
//                radix-2 and radix-4 instances side by side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_booth_multiplier;

  localparam int TMO = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0 = radix-2, index 1 = radix-4
  logic [1:0]  st8, busy8, done8;
  logic [7:0]  a8, b8;
  logic        s8;
  logic [15:0] p8 [2];

  logic [1:0]  st32, busy32, done32;
  logic [31:0] a32, b32;
  logic        s32;
  logic [63:0] p32 [2];

  seq_booth_multiplier #(.N(8), .RADIX4(1'b0)) u_r2_n8 (
    .clk(clk), .rst_n(rst_n), .start(st8[0]), .is_signed(s8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8[0]), .done(done8[0]), .product(p8[0]));
  seq_booth_multiplier #(.N(8), .RADIX4(1'b1)) u_r4_n8 (
    .clk(clk), .rst_n(rst_n), .start(st8[1]), .is_signed(s8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8[1]), .done(done8[1]), .product(p8[1]));
  seq_booth_multiplier #(.N(32), .RADIX4(1'b0)) u_r2_n32 (
    .clk(clk), .rst_n(rst_n), .start(st32[0]), .is_signed(s32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32[0]), .done(done32[0]), .product(p32[0]));
  seq_booth_multiplier #(.N(32), .RADIX4(1'b1)) u_r4_n32 (
    .clk(clk), .rst_n(rst_n), .start(st32[1]), .is_signed(s32),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32[1]), .done(done32[1]), .product(p32[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int it8(input int i);
    return (i != 0) ? 5 : 9;
  endfunction

  function automatic int it32(input int i);
    return (i != 0) ? 17 : 33;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    logic [15:0] x, y;
    x = sg ? {{8{a[7]}}, a} : {8'h00, a};
    y = sg ? {{8{b[7]}}, b} : {8'h00, b};
    return x * y;
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic sg);
    logic [63:0] x, y;
    x = sg ? {{32{a[31]}}, a} : {32'h0, a};
    y = sg ? {{32{b[31]}}, b} : {32'h0, b};
    return x * y;
  endfunction

  // One 8-bit operation on both radices; poke>0 re-pulses start mid-CALC.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic sg, input logic [15:0] exp, input int poke);
    int lat[2];
    int nb[2];
    int xtra[2];
    lat = '{-1, -1}; nb = '{0, 0}; xtra = '{0, 0};
    @(negedge clk); a8 = a; b8 = b; s8 = sg; st8 = 2'b11;
    @(posedge clk); #1; st8 = 2'b00; a8 = ~a; b8 = ~b; s8 = ~sg;
    for (int j = 0; j <= TMO; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      if (poke > 0 && j == poke) begin st8 = 2'b11; a8 = 8'h64; b8 = 8'h64; end
      else st8 = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (lat[i] < 0) begin
          if (busy8[i]) nb[i]++;
          if (done8[i]) begin
            lat[i] = j;
            chk($sformatf("%s r%0d prod", tag, i ? 4 : 2), 64'(p8[i]), 64'(exp));
          end
        end else if (done8[i]) xtra[i]++;
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    if (poke > 0) begin
      repeat (12) begin
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) if (done8[i]) xtra[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s r%0d latency", tag, i ? 4 : 2), 64'(lat[i]), 64'(it8(i)));
      chk($sformatf("%s r%0d busy cycles", tag, i ? 4 : 2), 64'(nb[i]), 64'(it8(i)));
      chk($sformatf("%s r%0d extra done", tag, i ? 4 : 2), 64'(xtra[i]), 64'd0);
    end
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input logic [63:0] exp);
    int lat[2];
    lat = '{-1, -1};
    @(negedge clk); a32 = a; b32 = b; s32 = sg; st32 = 2'b11;
    @(posedge clk); #1; st32 = 2'b00; a32 = ~a; b32 = ~b; s32 = ~sg;
    for (int j = 0; j <= TMO; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < 2; i++) begin
        if (lat[i] < 0 && done32[i]) begin
          lat[i] = j;
          chk($sformatf("%s r%0d prod", tag, i ? 4 : 2), p32[i], exp);
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    for (int i = 0; i < 2; i++)
      chk($sformatf("%s r%0d latency", tag, i ? 4 : 2), 64'(lat[i]), 64'(it32(i)));
  endtask

  // start held high: first op, accepted again straight out of DONE.
  task automatic b2b8(input logic [7:0] a1, input logic [7:0] b1, input logic [15:0] e1,
                      input logic [7:0] a2, input logic [7:0] b2, input logic [15:0] e2);
    int ph[2];
    int t1[2];
    ph = '{0, 0}; t1 = '{0, 0};
    @(negedge clk); a8 = a1; b8 = b1; s8 = 1'b1; st8 = 2'b11;
    @(posedge clk); #1; a8 = a2; b8 = b2;
    for (int j = 0; j <= TMO; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (done8[i]) begin
               chk($sformatf("b2b r%0d first prod", i ? 4 : 2), 64'(p8[i]), 64'(e1));
               t1[i] = j; ph[i] = 1;
             end
          1: begin
               chk($sformatf("b2b r%0d done low", i ? 4 : 2), 64'(done8[i]), 64'd0);
               chk($sformatf("b2b r%0d busy", i ? 4 : 2), 64'(busy8[i]), 64'd1);
               chk($sformatf("b2b r%0d prod held", i ? 4 : 2), 64'(p8[i]), 64'(e1));
               st8[i] = 1'b0; ph[i] = 2;
             end
          2: if (done8[i]) begin
               chk($sformatf("b2b r%0d second prod", i ? 4 : 2), 64'(p8[i]), 64'(e2));
               chk($sformatf("b2b r%0d second latency", i ? 4 : 2), 64'(j - t1[i]), 64'(it8(i) + 1));
               ph[i] = 3;
             end
          default: ;
        endcase
      end
      if (ph[0] == 3 && ph[1] == 3) break;
    end
    st8 = 2'b00;
    for (int i = 0; i < 2; i++)
      chk($sformatf("b2b r%0d completed", i ? 4 : 2), 64'(ph[i]), 64'd3);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ra, rb;
    logic [31:0] ra32, rb32;
    int nd;
    st8 = 2'b00; a8 = '0; b8 = '0; s8 = 1'b0;
    st32 = 2'b00; a32 = '0; b32 = '0; s32 = 1'b0;

    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset prod8", 64'(p8[i]), 64'd0);
      chk("reset busy8", 64'(busy8[i]), 64'd0);
      chk("reset done8", 64'(done8[i]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    op8("s -3*5",      8'hFD, 8'h05, 1'b1, 16'hFFF1, 0);
    op8("s -128*-128", 8'h80, 8'h80, 1'b1, 16'h4000, 0);
    op8("u 255*255",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
    op8("u 200*3",     8'hC8, 8'h03, 1'b0, 16'h0258, 0);
    op8("s 0*0",       8'h00, 8'h00, 1'b1, 16'h0000, 0);
    op8("s -128*127",  8'h80, 8'h7F, 1'b1, 16'hC080, 0);
    op8("s 127*-1",    8'h7F, 8'hFF, 1'b1, 16'hFF81, 0);
    op8("s -1*-1",     8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
    op8("u 128*2",     8'h80, 8'h02, 1'b0, 16'h0100, 0);

    op32("s min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    op32("u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    op32("s -1*5",    32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
    op32("u x*16",    32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);

    for (int r = 0; r < 4; r++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8("rnd8", ra, rb, r[0], ref8(ra, rb, r[0]), 0);
      ra32 = $urandom; rb32 = $urandom;
      op32("rnd32", ra32, rb32, r[0], ref32(ra32, rb32, r[0]));
    end

    // second start during CALC must be ignored
    op8("poke 7*9", 8'h07, 8'h09, 1'b1, 16'h003F, 2);

    b2b8(8'h0A, 8'h0A, 16'h0064, 8'hFE, 8'h03, 16'hFFFA);

    // asynchronous reset in the middle of an operation
    @(negedge clk); a8 = 8'h32; b8 = 8'hFE; s8 = 1'b1; st8 = 2'b11;
    @(posedge clk); #1; st8 = 2'b00;
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("abort prod8", 64'(p8[i]), 64'd0);
      chk("abort busy8", 64'(busy8[i]), 64'd0);
      chk("abort done8", 64'(done8[i]), 64'd0);
      chk("abort prod32", p32[i], 64'd0);
    end
    @(posedge clk); #2; rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 != 2'b00) nd++;
    end
    chk("abort no done", 64'(nd), 64'd0);
    op8("post-reset u 127*127", 8'h7F, 8'h7F, 1'b0, 16'h3F01, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
